// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned BEAT_BYTES = MEM_DATA_W / 8;

  // FSM encoding kept as plain constants so legacy code can match on raw values
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_I_BURST = 2'd1;
  localparam state_t ST_D_ACC   = 2'd2;
  localparam state_t ST_D_WAIT  = 2'd3;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Number of low address bits addressing bytes within one refill line
  function automatic int unsigned line_off_w(input int unsigned burst_len);
    return $clog2(burst_len * BEAT_BYTES);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-requester round-robin picker; bit 0 is the ICache, bit 1 the data side.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output owner_e     winner,
  output logic       valid
);

  // On a tie the requester not served last wins
  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      winner = (last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (req[1]) begin
      winner = OWN_D;
    end else begin
      winner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between ICache line refills and single-beat data accesses.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_last,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int unsigned       CNT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BEAT_STEP = ADDR_W'(BEAT_BYTES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << line_off_w(BURST_LEN)) - 1'b1);

  state_t              state_q, state_d;
  owner_e              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    rsp_cnt_q, rsp_cnt_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0] m_wstrb_q, m_wstrb_d;
  logic                i_gnt_q, i_gnt_d;
  logic                d_gnt_q, d_gnt_d;

  owner_e pick_winner;
  logic   pick_valid;
  logic   beat_acc;

  mem_arb_rr u_rr (
    .req        ({d_req, i_req}),
    .last_owner (last_owner_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign beat_acc = m_req_q & m_ready;

  // Next-state: arbitration in IDLE, beat issue and response counting while owned
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    issue_cnt_d  = issue_cnt_q;
    rsp_cnt_d    = rsp_cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wstrb_d    = m_wstrb_q;
    i_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          last_owner_d = pick_winner;
          issue_cnt_d  = '0;
          rsp_cnt_d    = '0;
          m_req_d      = 1'b1;
          if (pick_winner == OWN_I) begin
            i_gnt_d   = 1'b1;
            state_d   = ST_I_BURST;
            m_we_d    = 1'b0;
            m_addr_d  = i_addr & LINE_MASK;
            m_wdata_d = '0;
            m_wstrb_d = '0;
          end else begin
            d_gnt_d   = 1'b1;
            state_d   = ST_D_ACC;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
          end
        end
      end
      ST_I_BURST: begin
        // Issue and response sides advance independently and may overlap
        if (beat_acc) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_IDX) begin
            m_req_d = 1'b0;
          end else begin
            m_addr_d = m_addr_q + BEAT_STEP;
          end
        end
        if (m_rvalid) begin
          rsp_cnt_d = rsp_cnt_q + 1'b1;
          if (rsp_cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_D_ACC: begin
        if (beat_acc) begin
          m_req_d = 1'b0;
          state_d = m_we_q ? ST_IDLE : ST_D_WAIT;
        end
      end
      ST_D_WAIT: begin
        if (m_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_D;
      issue_cnt_q  <= '0;
      rsp_cnt_q    <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= '0;
      i_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      issue_cnt_q  <= issue_cnt_d;
      rsp_cnt_q    <= rsp_cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wstrb_q    <= m_wstrb_d;
      i_gnt_q      <= i_gnt_d;
      d_gnt_q      <= d_gnt_d;
    end
  end

  // Responses are forwarded only to the current owner; strays elsewhere are dropped
  always_comb begin
    i_rvalid = (state_q == ST_I_BURST) & m_rvalid;
    i_rdata  = i_rvalid ? m_rdata : '0;
    i_last   = i_rvalid & (rsp_cnt_q == LAST_IDX);
    d_rvalid = (state_q == ST_D_WAIT) & m_rvalid;
    d_rdata  = d_rvalid ? m_rdata : '0;
  end

  assign i_gnt   = i_gnt_q;
  assign d_gnt   = d_gnt_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;

endmodule
